clk_enable_gen: RTL and testbench

//  Multi-channel fractional clock-enable generator on a single system clock; successor to the fixed-ratio PLL wrapper.
//  One phase accumulator per channel yields a 1-cycle enable at f_refclk*inc/2^ACC_W; increments reprogrammable at run time.

---
 rtl/clk_enable_gen_pkg.sv | 14 +
 rtl/clk_enable_accum.sv | 41 ++++
 rtl/clk_enable_gen.sv | 105 ++++++++++
 tb/tb_clk_enable_gen.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/clk_enable_gen_pkg.sv
// Shared types and helpers for the fractional clock-enable generator.
package clk_enable_gen_pkg;

   typedef enum logic [0:0] {
      ST_SETTLE = 1'b0,
      ST_RUN    = 1'b1
   } state_e;

   // $clog2 that never returns 0, so single-entry selects still get a 1-bit port
   function automatic int ch_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/clk_enable_accum.sv
// One phase-accumulator channel: the carry out of acc+inc becomes a registered enable pulse.
module clk_enable_accum #(
   parameter int ACC_W = 32
) (
   input  logic             refclk,
   input  logic             rst,
   input  logic             clear,
   input  logic             run,
   input  logic [ACC_W-1:0] inc,
   output logic             ce
);

   logic [ACC_W-1:0] acc_q, acc_d;
   logic             ce_q, ce_d;
   logic [ACC_W:0]   sum;

   assign sum = {1'b0, acc_q} + {1'b0, inc};

   always_comb begin
      acc_d = acc_q;
      ce_d  = 1'b0;
      if (clear) begin
         acc_d = '0;
      end else if (run) begin
         {ce_d, acc_d} = sum;
      end
   end

   always_ff @(posedge refclk) begin
      if (rst) begin
         acc_q <= '0;
         ce_q  <= 1'b0;
      end else begin
         acc_q <= acc_d;
         ce_q  <= ce_d;
      end
   end

   assign ce = ce_q;

endmodule

// File: rtl/clk_enable_gen.sv
// Multi-channel fractional clock-enable generator with PLL-style lock/settle behaviour.
//
// state     | meaning
// ST_SETTLE | accumulators held at zero, settle counter running down, config not accepted
// ST_RUN    | channels accumulating, locked, one config write accepted per cycle
module clk_enable_gen
   import clk_enable_gen_pkg::*;
#(
   parameter int NUM_CH      = 2,
   parameter int ACC_W       = 32,
   parameter int LOCK_CYCLES = 16,
   parameter int HITLESS     = 0,
   parameter logic [NUM_CH*ACC_W-1:0] INC_INIT = {32'h6000_0000, 32'h2000_0000}
) (
   input  logic                        refclk,
   input  logic                        rst,
   input  logic [NUM_CH-1:0]           ch_en,
   input  logic                        cfg_valid,
   output logic                        cfg_ready,
   input  logic [ch_w(NUM_CH)-1:0]     cfg_ch,
   input  logic [ACC_W-1:0]            cfg_inc,
   output logic                        cfg_err,
   output logic [NUM_CH-1:0]           ce_out,
   output logic                        locked
);

   localparam int               CNT_W    = ch_w(LOCK_CYCLES);
   localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(LOCK_CYCLES - 1);

   state_e           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             err_q, err_d;
   logic [ACC_W-1:0] inc_q [NUM_CH];
   logic [ACC_W-1:0] inc_d [NUM_CH];

   logic              accept, ch_ok, wr_ok, resettle, clear_all;
   logic [NUM_CH-1:0] run_ch;

   assign accept    = cfg_valid & (state_q == ST_RUN);
   assign ch_ok     = (int'(cfg_ch) < NUM_CH);
   assign wr_ok     = accept & ch_ok;
   assign resettle  = wr_ok & (HITLESS == 0);
   assign clear_all = (state_q == ST_SETTLE) | resettle;
   assign err_d     = accept & ~ch_ok;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      inc_d   = inc_q;
      case (state_q)
         ST_SETTLE: begin
            if (cnt_q == '0) state_d = ST_RUN;
            else             cnt_d   = cnt_q - 1'b1;
         end
         ST_RUN: begin
            if (resettle) begin
               state_d = ST_SETTLE;
               cnt_d   = CNT_INIT;
            end
         end
         default: begin
            state_d = ST_SETTLE;
            cnt_d   = CNT_INIT;
         end
      endcase
      // the channel add on this edge still sees the old increment
      for (int i = 0; i < NUM_CH; i++) begin
         if (wr_ok && (int'(cfg_ch) == i)) inc_d[i] = cfg_inc;
      end
   end

   always_ff @(posedge refclk) begin
      if (rst) begin
         state_q <= ST_SETTLE;
         cnt_q   <= CNT_INIT;
         err_q   <= 1'b0;
         for (int i = 0; i < NUM_CH; i++) inc_q[i] <= INC_INIT[i*ACC_W +: ACC_W];
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         err_q   <= err_d;
         inc_q   <= inc_d;
      end
   end

   for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
      assign run_ch[g] = (state_q == ST_RUN) & ch_en[g];

      clk_enable_accum #(
         .ACC_W (ACC_W)
      ) u_accum (
         .refclk (refclk),
         .rst    (rst),
         .clear  (clear_all),
         .run    (run_ch[g]),
         .inc    (inc_q[g]),
         .ce     (ce_out[g])
      );
   end

   assign locked    = (state_q == ST_RUN);
   assign cfg_ready = (state_q == ST_RUN);
   assign cfg_err   = err_q;

endmodule

// File: tb/tb_clk_enable_gen.sv
// Bench for clk_enable_gen: a resettling 2-channel instance and a hitless 3-channel instance.
module tb_clk_enable_gen;

   localparam int     LOCK = 16;
   localparam longint MOD  = 64'h1_0000_0000;

   logic        refclk = 1'b0;
   logic        rst;
   logic [2:0]  ch_en;
   logic        cfg_valid;
   logic [1:0]  cfg_ch;
   logic [31:0] cfg_inc;

   logic       ready0, err0, locked0;
   logic [1:0] ce0;
   logic       ready1, err1, locked1;
   logic [2:0] ce1;

   int passed = 0;
   int total  = 0;

   always #5 refclk = ~refclk;

   clk_enable_gen #(
      .NUM_CH(2), .ACC_W(32), .LOCK_CYCLES(LOCK), .HITLESS(0),
      .INC_INIT({32'h6000_0000, 32'h2000_0000})
   ) dut0 (
      .refclk(refclk), .rst(rst), .ch_en(ch_en[1:0]), .cfg_valid(cfg_valid),
      .cfg_ready(ready0), .cfg_ch(cfg_ch[0:0]), .cfg_inc(cfg_inc), .cfg_err(err0),
      .ce_out(ce0), .locked(locked0)
   );

   clk_enable_gen #(
      .NUM_CH(3), .ACC_W(32), .LOCK_CYCLES(LOCK), .HITLESS(1),
      .INC_INIT({32'h4000_0000, 32'h6000_0000, 32'h2000_0000})
   ) dut1 (
      .refclk(refclk), .rst(rst), .ch_en(ch_en), .cfg_valid(cfg_valid),
      .cfg_ready(ready1), .cfg_ch(cfg_ch), .cfg_inc(cfg_inc), .cfg_err(err1),
      .ce_out(ce1), .locked(locked1)
   );

   // reference model: per-instance phase as a plain integer fraction of 2^32
   longint m_init [2][3];
   longint m_acc  [2][3];
   longint m_inc  [2][3];
   bit     m_ce   [2][3];
   int     m_settle [2];
   bit     m_err  [2];

   task automatic model_step(input int d);
      int nch = (d == 0) ? 2 : 3;
      bit hitless = (d == 1);
      int ch = (d == 0) ? int'(cfg_ch[0]) : int'(cfg_ch);
      bit lk = (m_settle[d] == 0);
      bit wr;
      longint s;
      if (rst) begin
         for (int c = 0; c < 3; c++) begin
            m_acc[d][c] = 0; m_inc[d][c] = m_init[d][c]; m_ce[d][c] = 0;
         end
         m_settle[d] = LOCK;
         m_err[d] = 0;
         return;
      end
      m_err[d] = cfg_valid && lk && (ch >= nch);
      wr = cfg_valid && lk && (ch < nch);
      if (!lk) begin
         m_settle[d]--;
         for (int c = 0; c < 3; c++) m_ce[d][c] = 0;
      end else if (wr && !hitless) begin
         m_inc[d][ch] = longint'(cfg_inc);
         for (int c = 0; c < 3; c++) begin m_acc[d][c] = 0; m_ce[d][c] = 0; end
         m_settle[d] = LOCK;
      end else begin
         for (int c = 0; c < nch; c++) begin
            if (ch_en[c]) begin
               s = m_acc[d][c] + m_inc[d][c];
               m_ce[d][c]  = (s >= MOD);
               m_acc[d][c] = s % MOD;
            end else begin
               m_ce[d][c] = 0;
            end
         end
         if (wr) m_inc[d][ch] = longint'(cfg_inc);
      end
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      else passed++;
   endtask

   task automatic cycle();
      logic [2:0] e0, e1;
      @(posedge refclk);
      model_step(0);
      model_step(1);
      #1;
      e0 = '0; e1 = '0;
      for (int c = 0; c < 3; c++) begin
         e0[c] = (c < 2) ? m_ce[0][c] : 1'b0;
         e1[c] = m_ce[1][c];
      end
      chk("d0.locked", locked0, m_settle[0] == 0);
      chk("d0.ready",  ready0,  m_settle[0] == 0);
      chk("d0.err",    err0,    m_err[0]);
      chk("d0.ce",     ce0,     e0[1:0]);
      chk("d1.locked", locked1, m_settle[1] == 0);
      chk("d1.ready",  ready1,  m_settle[1] == 0);
      chk("d1.err",    err1,    m_err[1]);
      chk("d1.ce",     ce1,     e1);
   endtask

   task automatic drive(input bit r, input bit [2:0] e, input bit v, input bit [1:0] ch,
                        input logic [31:0] inc);
      rst = r; ch_en = e; cfg_valid = v; cfg_ch = ch; cfg_inc = inc;
   endtask

   typedef struct {
      bit          r;
      bit [2:0]    en;
      bit          v;
      bit [1:0]    ch;
      logic [31:0] inc;
      int          reps;
      bit          lk;
      bit [1:0]    ce;
   } vec_t;

   vec_t tbl [$];

   function automatic vec_t mk(input bit r, input bit [2:0] en, input bit v, input bit [1:0] ch,
                               input logic [31:0] inc, input int reps, input bit lk,
                               input bit [1:0] ce);
      vec_t t;
      t.r = r; t.en = en; t.v = v; t.ch = ch; t.inc = inc; t.reps = reps; t.lk = lk; t.ce = ce;
      return t;
   endfunction

   initial begin
      m_init[0] = '{64'h2000_0000, 64'h6000_0000, 64'h0};
      m_init[1] = '{64'h2000_0000, 64'h6000_0000, 64'h4000_0000};
      drive(1, 3'b111, 0, 0, 0);

      // reset, settle with a request held (never taken), default cadence, then a resettling write
      tbl.push_back(mk(1, 3'b111, 0, 0, 32'h0,         2,  0, 2'b00));
      tbl.push_back(mk(0, 3'b111, 1, 1, 32'h8000_0000, 15, 0, 2'b00));
      tbl.push_back(mk(0, 3'b111, 1, 1, 32'h8000_0000, 1,  1, 2'b00));
      tbl.push_back(mk(0, 3'b111, 0, 0, 32'h0,         2,  1, 2'b00));
      tbl.push_back(mk(0, 3'b111, 0, 0, 32'h0,         1,  1, 2'b10));
      tbl.push_back(mk(0, 3'b111, 0, 0, 32'h0,         2,  1, 2'b00));
      tbl.push_back(mk(0, 3'b111, 0, 0, 32'h0,         1,  1, 2'b10));
      tbl.push_back(mk(0, 3'b111, 0, 0, 32'h0,         1,  1, 2'b00));
      tbl.push_back(mk(0, 3'b111, 0, 0, 32'h0,         1,  1, 2'b11));
      tbl.push_back(mk(0, 3'b111, 1, 1, 32'h8000_0000, 1,  0, 2'b00));
      tbl.push_back(mk(0, 3'b111, 0, 0, 32'h0,         15, 0, 2'b00));
      tbl.push_back(mk(0, 3'b111, 0, 0, 32'h0,         1,  1, 2'b00));
      for (int k = 0; k < 3; k++) begin
         tbl.push_back(mk(0, 3'b111, 0, 0, 32'h0, 1, 1, 2'b00));
         tbl.push_back(mk(0, 3'b111, 0, 0, 32'h0, 1, 1, 2'b10));
      end
      tbl.push_back(mk(0, 3'b111, 0, 0, 32'h0,         1,  1, 2'b00));
      tbl.push_back(mk(0, 3'b111, 0, 0, 32'h0,         1,  1, 2'b11));

      foreach (tbl[i]) begin
         for (int r = 0; r < tbl[i].reps; r++) begin
            drive(tbl[i].r, tbl[i].en, tbl[i].v, tbl[i].ch, tbl[i].inc);
            cycle();
            chk("tbl.locked", locked0, tbl[i].lk);
            chk("tbl.ce",     ce0,     tbl[i].ce);
         end
      end

      // out-of-range channel on the 3-channel instance: one-cycle error pulse
      drive(0, 3'b111, 1, 3, 32'h1234_5678);
      cycle();
      chk("err1.pulse", err1, 1'b1);
      drive(0, 3'b111, 0, 0, 0);
      cycle();
      chk("err1.clear", err1, 1'b0);
      repeat (20) cycle();

      // ch_en[1] low for 5 cycles: no ch1 pulses, phase resumes from held value
      drive(0, 3'b101, 0, 0, 0);
      for (int k = 0; k < 5; k++) begin
         cycle();
         chk("hold.ce0_1", ce0[1], 1'b0);
         chk("hold.ce1_1", ce1[1], 1'b0);
      end
      drive(0, 3'b111, 0, 0, 0);
      repeat (20) cycle();

      // reset in the middle of a settle, with a request pending
      drive(0, 3'b111, 1, 0, 32'h4000_0000);
      cycle();
      chk("rs.resettle", locked0, 1'b0);
      drive(0, 3'b111, 0, 0, 0);
      repeat (5) cycle();
      drive(1, 3'b111, 1, 2, 32'h0100_0000);
      cycle();
      chk("rs.locked0", locked0, 1'b0);
      chk("rs.locked1", locked1, 1'b0);
      chk("rs.err1",    err1,    1'b0);
      drive(0, 3'b111, 1, 2, 32'h0100_0000);
      repeat (15) cycle();
      chk("rs.still_settling", locked0, 1'b0);
      drive(0, 3'b111, 0, 0, 0);
      cycle();
      chk("rs.relock", locked0, 1'b1);
      repeat (16) cycle();

      // randomized traffic against the model
      for (int n = 0; n < 3000; n++) begin
         logic [31:0] inc;
         case ($urandom_range(0, 3))
            0:       inc = 32'h0;
            1:       inc = 32'h8000_0000;
            2:       inc = $urandom;
            default: inc = $urandom >> 2;
         endcase
         drive($urandom_range(0, 299) == 0,
               ($urandom_range(0, 9) == 0) ? 3'($urandom) : 3'b111,
               $urandom_range(0, 39) == 0,
               2'($urandom),
               inc);
         cycle();
      end

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
